// File: rtl/sad_accum_engine_if.sv
// Handshake bundle for the SAD accumulation engine: input beat channel with
// its per-beat controls, and the frame result channel.
interface sad_accum_engine_if #(
  parameter int DATA_W = 5,
  parameter int LANES  = 2,
  parameter int ACC_W  = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_x;
  logic [LANES*DATA_W-1:0] in_y;
  logic                    mode_signed;
  logic                    clear;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_W-1:0]        out_sum;
  logic                    out_sat;

  // Producer/consumer side (drives beats, accepts results).
  modport master (
    output in_valid, in_x, in_y, mode_signed, clear, out_ready,
    input  in_ready, out_valid, out_sum, out_sat
  );

  // Engine side.
  modport slave (
    input  in_valid, in_x, in_y, mode_signed, clear, out_ready,
    output in_ready, out_valid, out_sum, out_sat
  );
endinterface

// File: rtl/sad_accum_engine.sv
// Multi-lane |x-y| engine accumulating a saturating sum of absolute
// differences over FRAME_LEN accepted beats. Each frame result is held on a
// valid/ready output and mirrored, inverted, onto active-low board LEDs.
module sad_accum_engine #(
  parameter int DATA_W    = 5,
  parameter int LANES     = 2,
  parameter int FRAME_LEN = 4,
  parameter int ACC_W     = 8,
  parameter int LED_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  sad_accum_engine_if.slave bus,
  output logic [LED_W-1:0] boardLED
);

  localparam int SUM_W = DATA_W + $clog2(LANES);
  localparam int ADD_W = ACC_W + 1;
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic [ACC_W-1:0] r_out_sum;
  logic             r_out_sat;
  logic [LED_W-1:0] r_led;

  logic [DATA_W-1:0] w_diff [LANES];
  logic [SUM_W-1:0]  w_beat_sum;
  logic [ADD_W-1:0]  w_add;
  logic              w_ovf;
  logic [ACC_W-1:0]  w_acc_next;
  logic              w_accept;
  logic              w_last;

  // Per-lane absolute difference. The modular subtraction of the smaller
  // operand from the larger always fits in DATA_W unsigned bits, in both modes.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DATA_W-1:0] w_x;
    logic [DATA_W-1:0] w_y;
    logic              w_x_gt;

    assign w_x    = bus.in_x[g*DATA_W +: DATA_W];
    assign w_y    = bus.in_y[g*DATA_W +: DATA_W];
    assign w_x_gt = bus.mode_signed ? ($signed(w_x) > $signed(w_y)) : (w_x > w_y);
    assign w_diff[g] = w_x_gt ? (w_x - w_y) : (w_y - w_x);
  end

  // Sum of the lane differences for the current beat.
  // NOTE: every always_comb output gets a default before any branch or loop,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_beat_sum = w_beat_sum + SUM_W'(w_diff[i]);
    end
  end

  // Saturating add: one spare bit catches the overflow, then clamp.
  assign w_add      = {1'b0, r_acc} + ADD_W'(w_beat_sum);
  assign w_ovf      = w_add[ACC_W];
  assign w_acc_next = w_ovf ? ACC_MAX : w_add[ACC_W-1:0];

  assign w_accept = bus.in_valid & (r_state == ST_ACCUM);
  assign w_last   = (r_cnt == LAST_CNT);

  // FSM state register.
  // NOTE: clocked blocks use non-blocking assignments so every register sees
  // pre-edge values of the others, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_ACCUM;
    else     r_state <= w_state_next;
  end

  // Next-state and handshake outputs; a clear on the last beat drops it.
  always_comb begin
    w_state_next  = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (r_state)
      ST_ACCUM: begin
        bus.in_ready = 1'b1;
        if (w_accept && !bus.clear && w_last) w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_next = ST_ACCUM;
      end
      default: w_state_next = ST_ACCUM;
    endcase
  end

  // Accumulator, beat count, sticky saturation and the held frame result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sat     <= 1'b0;
      r_out_sum <= '0;
      r_out_sat <= 1'b0;
      r_led     <= '1;
    end else if (r_state == ST_ACCUM) begin
      if (bus.clear) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_sat <= 1'b0;
      end else if (w_accept) begin
        if (w_last) begin
          r_out_sum <= w_acc_next;
          r_out_sat <= r_sat | w_ovf;
          r_led     <= ~w_acc_next[LED_W-1:0];
          r_acc     <= '0;
          r_cnt     <= '0;
          r_sat     <= 1'b0;
        end else begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          r_sat <= r_sat | w_ovf;
        end
      end
    end
  end

  assign bus.out_sum = r_out_sum;
  assign bus.out_sat = r_out_sat;
  assign boardLED    = r_led;

endmodule

// File: tb/tb_sad_accum_engine.sv
// Directed plus random stimulus for sad_accum_engine; a behavioural model
// pushes expected frame results into per-DUT queues which a negedge monitor
// pops whenever a result handshake is about to complete.
module tb_sad_accum_engine;

  localparam int DATA_W    = 5;
  localparam int LANES     = 2;
  localparam int FRAME_LEN = 4;
  localparam int LED_W     = 6;
  localparam int XW        = LANES * DATA_W;

  typedef struct {
    int sum;
    int sat;
    int led;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sad_accum_engine_if #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(8)) bus  ();
  sad_accum_engine_if #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(7)) bus7 ();
  logic [LED_W-1:0] led0;
  logic [LED_W-1:0] led7;

  sad_accum_engine #(
    .DATA_W(DATA_W), .LANES(LANES), .FRAME_LEN(FRAME_LEN), .ACC_W(8), .LED_W(LED_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .boardLED(led0)
  );

  sad_accum_engine #(
    .DATA_W(DATA_W), .LANES(LANES), .FRAME_LEN(FRAME_LEN), .ACC_W(7), .LED_W(LED_W)
  ) dut7 (
    .clk(clk), .rst(rst), .bus(bus7), .boardLED(led7)
  );

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q7[$];
  exp_t e0;
  exp_t e7;
  int   m_acc [2] = '{0, 0};
  int   m_cnt [2] = '{0, 0};
  int   m_sat [2] = '{0, 0};
  int   acc_max [2] = '{255, 127};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lane_val(input int v, input bit sgn);
    if (sgn && v >= (1 << (DATA_W - 1))) return v - (1 << DATA_W);
    return v;
  endfunction

  task automatic model_beat(input int d, input logic [XW-1:0] x, input logic [XW-1:0] y,
                            input bit sgn);
    int   s;
    int   a;
    int   b;
    exp_t e;
    s = 0;
    for (int i = 0; i < LANES; i++) begin
      a = lane_val(int'(x[i*DATA_W +: DATA_W]), sgn);
      b = lane_val(int'(y[i*DATA_W +: DATA_W]), sgn);
      s += (a > b) ? (a - b) : (b - a);
    end
    m_acc[d] += s;
    if (m_acc[d] > acc_max[d]) begin
      m_acc[d] = acc_max[d];
      m_sat[d] = 1;
    end
    if (m_cnt[d] == FRAME_LEN - 1) begin
      e.sum = m_acc[d];
      e.sat = m_sat[d];
      e.led = (~m_acc[d]) & ((1 << LED_W) - 1);
      if (d == 0) q0.push_back(e);
      else        q7.push_back(e);
      m_acc[d] = 0;
      m_cnt[d] = 0;
      m_sat[d] = 0;
    end else begin
      m_cnt[d]++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and wait (bounded) until it is accepted.
  task automatic drive_beat(input int d, input logic [XW-1:0] x, input logic [XW-1:0] y,
                            input bit sgn);
    int waited;
    waited = 0;
    if (d == 0) begin
      bus.in_valid = 1'b1; bus.in_x = x; bus.in_y = y; bus.mode_signed = sgn;
    end else begin
      bus7.in_valid = 1'b1; bus7.in_x = x; bus7.in_y = y; bus7.mode_signed = sgn;
    end
    while (((d == 0) ? bus.in_ready : bus7.in_ready) !== 1'b1) begin
      if (waited >= 50) begin
        check("in_ready_timeout", (d == 0) ? bus.in_ready : bus7.in_ready, 1);
        bus.in_valid  = 1'b0;
        bus7.in_valid = 1'b0;
        return;
      end
      tick();
      waited++;
    end
    tick();
    model_beat(d, x, y, sgn);
    if (d == 0) bus.in_valid = 1'b0;
    else        bus7.in_valid = 1'b0;
  endtask

  task automatic send_frame(input int d, input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                            input bit sgn);
    for (int b = 0; b < FRAME_LEN; b++) drive_beat(d, {LANES{x}}, {LANES{y}}, sgn);
  endtask

  // Result scoreboard: the handshake completes at the next posedge.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (q0.size() == 0) begin
        check("unexpected_result0", bus.out_valid, 0);
      end else begin
        e0 = q0.pop_front();
        check("sb_sum0", bus.out_sum, e0.sum);
        check("sb_sat0", bus.out_sat, e0.sat);
        check("sb_led0", led0, e0.led);
      end
    end
    if (rst === 1'b0 && bus7.out_valid === 1'b1 && bus7.out_ready === 1'b1) begin
      if (q7.size() == 0) begin
        check("unexpected_result7", bus7.out_valid, 0);
      end else begin
        e7 = q7.pop_front();
        check("sb_sum7", bus7.out_sum, e7.sum);
        check("sb_sat7", bus7.out_sat, e7.sat);
        check("sb_led7", led7, e7.led);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.in_x = '0;  bus.in_y = '0;
    bus.mode_signed = 1'b0;  bus.clear = 1'b0;  bus.out_ready = 1'b1;
    bus7.in_valid = 1'b0; bus7.in_x = '0; bus7.in_y = '0;
    bus7.mode_signed = 1'b0; bus7.clear = 1'b0; bus7.out_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_out_sat", bus.out_sat, 0);
    check("rst_led", led0, 6'b111111);
    rst = 1'b0;
    tick();

    // Test 1: unsigned x=10 y=5, latency and one-cycle out_valid pulse
    for (int b = 0; b < FRAME_LEN - 1; b++) drive_beat(0, {LANES{5'd10}}, {LANES{5'd5}}, 1'b0);
    check("t1_valid_early", bus.out_valid, 0);
    drive_beat(0, {LANES{5'd10}}, {LANES{5'd5}}, 1'b0);
    check("t1_valid_rise", bus.out_valid, 1);
    check("t1_sum", bus.out_sum, 40);
    check("t1_sat", bus.out_sat, 0);
    check("t1_led", led0, 6'b010111);
    tick();
    check("t1_valid_fall", bus.out_valid, 0);
    check("t1_ready_back", bus.in_ready, 1);

    // Test 2: symmetry, then random frames against the model
    send_frame(0, 5'd5, 5'd10, 1'b0);
    check("t2_sym_sum", bus.out_sum, 40);
    tick();
    for (int f = 0; f < 100; f++) begin
      for (int b = 0; b < FRAME_LEN; b++) begin
        drive_beat(0, XW'($urandom), XW'($urandom), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) tick();
      end
    end
    repeat (2) tick();

    // Test 3: signed extremes vs unsigned interpretation
    send_frame(0, 5'b01111, 5'b10000, 1'b1);
    check("t3_signed_sum", bus.out_sum, 248);
    tick();
    send_frame(0, 5'b01111, 5'b10000, 1'b0);
    check("t3_unsigned_sum", bus.out_sum, 8);
    tick();

    // Test 4: 7-bit accumulator saturates, next frame starts clean
    send_frame(1, 5'd31, 5'd0, 1'b0);
    check("t4_sat_sum", bus7.out_sum, 127);
    check("t4_sat_flag", bus7.out_sat, 1);
    tick();
    send_frame(1, 5'd0, 5'd0, 1'b0);
    check("t4_zero_sum", bus7.out_sum, 0);
    check("t4_zero_sat", bus7.out_sat, 0);
    tick();

    // Test 5: backpressure, beats offered during HOLD are ignored
    bus.out_ready = 1'b0;
    send_frame(0, 5'd3, 5'd1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_x = XW'($urandom);
      bus.in_y = XW'($urandom);
      check("t5_in_ready", bus.in_ready, 0);
      check("t5_out_valid", bus.out_valid, 1);
      check("t5_sum_stable", bus.out_sum, 16);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("t5_release_ready", bus.in_ready, 1);
    send_frame(0, 5'd2, 5'd1, 1'b0);
    check("t5_next_sum", bus.out_sum, 8);
    tick();

    // Test 6: clear beats a simultaneous valid beat
    drive_beat(0, {LANES{5'd6}}, {LANES{5'd1}}, 1'b0);
    drive_beat(0, {LANES{5'd6}}, {LANES{5'd1}}, 1'b0);
    bus.clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_x = {LANES{5'd20}};
    bus.in_y = {LANES{5'd0}};
    tick();
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    m_acc[0] = 0; m_cnt[0] = 0; m_sat[0] = 0;
    send_frame(0, 5'd2, 5'd1, 1'b0);
    check("t6_clear_sum", bus.out_sum, 8);
    tick();

    // Test 6b: reset while holding a result
    bus.out_ready = 1'b0;
    send_frame(0, 5'd9, 5'd1, 1'b0);
    check("t6_hold_valid", bus.out_valid, 1);
    check("t6_hold_sum", bus.out_sum, 64);
    void'(q0.pop_front());
    rst = 1'b1;
    tick();
    check("t6_rst_valid", bus.out_valid, 0);
    check("t6_rst_sum", bus.out_sum, 0);
    check("t6_rst_led", led0, 6'b111111);
    check("t6_rst_ready", bus.in_ready, 1);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();

    check("q0_drained", q0.size(), 0);
    check("q7_drained", q7.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sad_accum_engine.md
Name: sad_accum_engine

Overview:
Parametrised successor to the single absolute-difference LED demo. It accepts a stream of multi-lane operand pairs over a valid/ready handshake and computes |x−y| per lane, in unsigned or signed mode. Lane results are accumulated into a saturating sum-of-absolute-differences (SAD) over a fixed-length frame. Each completed frame result is presented on an output handshake and mirrored, inverted, onto the active-low board LEDs.

Parameters:
DATA_W, 5, operand width per lane
LANES, 2, operand pairs per input beat
FRAME_LEN, 4, accepted beats per frame (≥1)
ACC_W, 8, accumulator/result width (≥ DATA_W+clog2(LANES))
LED_W, 6, board LED count (≤ ACC_W)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  input beat valid
in_ready  out  1  engine can accept beat
in_x  in  LANES*DATA_W  lane operands x, lane i at [i*DATA_W +: DATA_W]
in_y  in  LANES*DATA_W  lane operands y, same packing
mode_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled per accepted beat
clear  in  1  abort current frame: zero accumulator and beat count
out_valid  out  1  frame result valid
out_ready  in  1  consumer accepts result
out_sum  out  ACC_W  frame SAD, saturated
out_sat  out  1  saturation occurred during this frame
boardLED  out  LED_W  active-low display, ~out_sum[LED_W-1:0] of last frame

Behaviour:
- Decided: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: in_ready=1; out_valid=0; out_sum=0; out_sat=0; boardLED all ones (LEDs off). Accumulator, beat count and sat flag are cleared; FSM returns to ACCUM.
- Per-lane diff: d_i = (x_i > y_i) ? x_i−y_i : y_i−x_i, with the comparison unsigned or signed per mode_signed. The result is an unsigned DATA_W-bit value and cannot overflow in either mode (e.g. 15 − (−16) = 31).
- beat_sum = Σ d_i at width DATA_W+clog2(LANES); combinational within the accept cycle.
- Accept = in_valid & in_ready.
- FSM ACCUM: in_ready=1, out_valid=0.
  - Accept with count<FRAME_LEN−1: acc ← sat(acc+beat_sum); count++.
  - Accept with count=FRAME_LEN−1: out_sum ← sat(acc+beat_sum); out_sat ← sat_flag | overflow on this add; boardLED ← ~out_sum_next[LED_W-1:0]; acc, count, sat_flag ← 0; go to HOLD.
  - Latency: out_valid rises the cycle after the last beat is accepted.
- FSM HOLD: in_ready=0, out_valid=1; out_sum and out_sat are stable.
  - out_ready=1 → ACCUM next cycle; in_ready returns to 1 that cycle. There is no same-cycle bypass.
  - in_valid is ignored while in HOLD.
- Saturation: any add exceeding 2^ACC_W−1 clamps acc to 2^ACC_W−1 and sets sat_flag (sticky until frame end). Once at the clamp, acc stays there.
- clear in ACCUM: acc, count, sat_flag ← 0. clear has priority over a simultaneous accept; that beat is dropped. clear in HOLD has no effect on the held result.
- rst overrides everything, including mid-frame and mid-HOLD.
- boardLED changes only on frame completion or reset; it retains the last frame value through subsequent frames.
- FRAME_LEN=1: every accepted beat completes a frame.

Test Plan:
1. Defaults, unsigned, 4 beats with all lanes x=10, y=5, out_ready=1 → out_valid pulses 1 cycle after 4th accept; out_sum=40, out_sat=0, boardLED=6'b010111.
2. Same stimulus with x=5, y=10 → out_sum=40 (symmetry). Random lanes over 100 frames → matches scoreboard.
3. mode_signed=1, x=5'b01111, y=5'b10000 on all lanes, 4 beats → out_sum=248. Same frame with mode_signed=0 → out_sum=8.
4. ACC_W=7 override, unsigned, x=31, y=0 all lanes, 4 beats → out_sum=127, out_sat=1. Next frame of zeros → out_sum=0, out_sat=0.
5. Backpressure: complete a frame, hold out_ready=0 for 5 cycles while driving in_valid=1 → in_ready=0 and out_sum stable throughout; no beats counted. Release → ACCUM next cycle; next frame counts from 0.
6. Two beats of diff 5, then clear concurrent with a valid beat, then 4 beats of diff 1 → out_sum=8. Separately, rst during HOLD → out_valid=0, out_sum=0, boardLED=6'b111111 on the next cycle.
